mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width driven to the memory.
REQ-002 Parameter MAX_D_STREAK, default 4, number of consecutive data grants allowed while fetch waits.
REQ-003 CLK  input  1  rising-edge clock; single clock domain.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 I_REQ  input  1  fetch read request; held by the requester until granted.
REQ-006 I_ADDR  input  32  fetch byte address.
REQ-007 I_GNT  output  1  fetch request accepted this cycle.
REQ-008 I_RVALID  output  1  fetch read data valid.
REQ-009 I_RDATA  output  32  fetch read data.
REQ-010 D_REQ  input  1  data-port request; held by the requester until granted.
REQ-011 D_WE  input  1  data-port write when 1, read when 0.
REQ-012 D_BE  input  4  data-port byte enables; used for writes only.
REQ-013 D_ADDR  input  32  data-port byte address.
REQ-014 D_WDATA  input  32  data-port write data.
REQ-015 D_GNT, D_RVALID, D_RDATA  output  1/1/32  data-port grant, read valid and read data.
REQ-016 M_EN, M_WE, M_BE, M_ADDR, M_WDATA  output  1/1/4/ADDR_W/32  single-port memory command.
REQ-017 M_RDATA  input  32  memory read data; valid exactly one cycle after the M_EN/!M_WE cycle.

Function
REQ-018 The block SHALL arbitrate one single-port memory between the fetch port and the data port, issuing at most one grant per cycle.
REQ-019 Grants SHALL be combinational from the current-cycle requests and the streak counter, with zero-cycle grant latency.
REQ-020 Default priority SHALL be data over fetch.
REQ-021 When streak == MAX_D_STREAK and I_REQ=1, I_GNT SHALL be 1 and D_GNT 0 that cycle, even if D_REQ=1.
REQ-022 The streak counter (width clog2(MAX_D_STREAK+1)) SHALL behave as follows:
  - increment on a D grant while I_REQ=1;
  - clear on any I grant or any cycle with I_REQ=0;
  - never exceed MAX_D_STREAK.
REQ-023 M_EN SHALL equal I_GNT|D_GNT.
REQ-024 On a D grant the memory command SHALL be: M_WE=D_WE, M_BE=D_BE, M_ADDR=D_ADDR[ADDR_W+1:2], M_WDATA=D_WDATA.
REQ-025 On an I grant the memory command SHALL be: M_WE=0, M_BE=4'hF, M_ADDR=I_ADDR[ADDR_W+1:2], M_WDATA=0.
REQ-026 With no grant, M_WE=0, M_BE=0, M_ADDR=0 and M_WDATA=0.
REQ-027 A registered response-owner state (NONE/IFETCH/DREAD) SHALL load IFETCH on an I grant, DREAD on a D read grant, and NONE otherwise (no grant or a D write grant).
REQ-028 Response timing:
  - I_RVALID SHALL be 1 exactly in the cycle after an I grant.
  - D_RVALID SHALL be 1 exactly in the cycle after a D read grant.
  - Writes SHALL produce no RVALID.
REQ-029 I_RDATA and D_RDATA SHALL both equal M_RDATA combinationally; consumers qualify them with RVALID.
REQ-030 Back-to-back grants every cycle SHALL be supported; a response and a new grant in the same cycle are independent.
REQ-031 Byte-address bits [1:0] SHALL be ignored for both ports, with no error reported.
REQ-032 A request withdrawn before grant SHALL be dropped silently, with no state change other than the streak rule.

Reset
REQ-033 While RST=1 the block SHALL force:
  - I_GNT=0, D_GNT=0, M_EN=0, M_WE=0;
  - I_RVALID=0 and D_RVALID=0 in the following cycle;
  - streak cleared and owner set to NONE.
REQ-034 A grant pending when RST rises SHALL produce no RVALID after reset, and the first cycle after RST falls SHALL arbitrate normally.

Verification
REQ-035 Fetch only: I_REQ=1, I_ADDR=0x0000_0010, M_RDATA=0xDEADBEEF next cycle -> I_GNT=1, M_ADDR=4, M_BE=F; next cycle I_RVALID=1, I_RDATA=0xDEADBEEF, D_RVALID=0.
REQ-036 Data write vs fetch: D_REQ=1, D_WE=1, D_BE=4'b0011, D_ADDR=0x20, D_WDATA=0x1234 with I_REQ=1 -> D_GNT=1, I_GNT=0, M_WE=1, M_ADDR=8; next cycle no RVALID.
REQ-037 Starvation guard, MAX_D_STREAK=4: D_REQ and I_REQ held high for 10 cycles -> grant pattern D,D,D,D,I,D,D,D,D,I.
REQ-038 Back-to-back reads: D read at cycle 0, I read at cycle 1 -> D_RVALID only at cycle 1 and I_RVALID only at cycle 2, each carrying that cycle's M_RDATA.
REQ-039 Reset mid-operation: I grant at cycle 0, RST=1 at cycle 1 -> I_RVALID=0 at cycle 1, all grants 0 while RST=1, and streak=0 and normal arbitration on the cycle RST falls.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: arbitrates one single-port synchronous memory between an instruction
// fetch port and a data port. Data wins by default; a streak counter lets fetch
// through after MAX_D_STREAK consecutive data grants while fetch was waiting.
// Grants are combinational; the read-response owner is tracked one cycle.
module mem_arb #(
  parameter int ADDR_W       = 14,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              M_EN,
  output logic              M_WE,
  output logic [3:0]        M_BE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  input  logic [31:0]       M_RDATA
);

  // A zero-length streak still needs a one-bit counter that simply stays at 0.
  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DREAD  = 2'd2
  } owner_e;

  logic [SW-1:0] streak_q, streak_d;
  owner_e        owner_q, owner_d;
  logic          i_gnt_s, d_gnt_s;

  // Byte-offset bits and the address bits above the memory window are ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^{I_ADDR, D_ADDR};

  // Grant selection: data first, unless fetch has waited out a full streak.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (RST) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (I_REQ && (!D_REQ || (streak_q == STREAK_MAX))) begin
      i_gnt_s = 1'b1;
    end else if (D_REQ) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Next streak count and next response owner.
  always_comb begin
    streak_d = streak_q;
    owner_d  = OWN_NONE;
    if (RST) begin
      streak_d = '0;
      owner_d  = OWN_NONE;
    end else begin
      // The streak only measures data grants taken while fetch is waiting.
      if (!I_REQ || i_gnt_s) begin
        streak_d = '0;
      end else if (d_gnt_s && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + SW'(1'b1);
      end else begin
        streak_d = streak_q;
      end
      // Writes return nothing, so they leave the response slot empty.
      if (i_gnt_s) begin
        owner_d = OWN_IFETCH;
      end else if (d_gnt_s && !D_WE) begin
        owner_d = OWN_DREAD;
      end else begin
        owner_d = OWN_NONE;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

  // Memory command mux; an idle cycle drives an all-zero command.
  always_comb begin
    M_WE    = 1'b0;
    M_BE    = 4'h0;
    M_ADDR  = '0;
    M_WDATA = 32'h0000_0000;
    if (i_gnt_s) begin
      M_WE    = 1'b0;
      M_BE    = 4'hF;
      M_ADDR  = I_ADDR[ADDR_W+1:2];
      M_WDATA = 32'h0000_0000;
    end else if (d_gnt_s) begin
      M_WE    = D_WE;
      M_BE    = D_BE;
      M_ADDR  = D_ADDR[ADDR_W+1:2];
      M_WDATA = D_WDATA;
    end else begin
      M_WE    = 1'b0;
      M_BE    = 4'h0;
      M_ADDR  = '0;
      M_WDATA = 32'h0000_0000;
    end
  end

  assign I_GNT = i_gnt_s;
  assign D_GNT = d_gnt_s;
  assign M_EN  = i_gnt_s | d_gnt_s;

  // Reset also masks a response that was already in flight when it rose.
  assign I_RVALID = !RST && (owner_q == OWN_IFETCH);
  assign D_RVALID = !RST && (owner_q == OWN_DREAD);
  assign I_RDATA  = M_RDATA;
  assign D_RDATA  = M_RDATA;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: drives mem_arb with directed and random traffic, emulates the
// memory behind it, and checks every cycle against a transaction-level model.
module tb_mem_arb;

  localparam int ADDR_W = 14;
  localparam int MAX_D  = 4;

  logic              CLK, RST;
  logic              I_REQ, I_GNT, I_RVALID;
  logic [31:0]       I_ADDR, I_RDATA;
  logic              D_REQ, D_WE, D_GNT, D_RVALID;
  logic [3:0]        D_BE;
  logic [31:0]       D_ADDR, D_WDATA, D_RDATA;
  logic              M_EN, M_WE;
  logic [3:0]        M_BE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [31:0]       M_WDATA, M_RDATA;

  mem_arb #(.ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_EN(M_EN), .M_WE(M_WE), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_RDATA(M_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Memory contents: env_mem follows the DUT's commands, ref_mem the model's.
  logic [31:0] env_mem [int];
  logic [31:0] ref_mem [int];

  // Previous-cycle command seen on the memory port.
  bit          c_en = 1'b0, c_we = 1'b0;
  logic [3:0]  c_be = 4'h0;
  int          c_addr = 0;
  logic [31:0] c_wdata = 32'h0;

  // Model state: data grants fetch has sat through, and the pending response.
  int          run = 0;
  bit          pend_i = 1'b0, pend_d = 1'b0;
  logic [31:0] pend_data = 32'h0;
  bit          m_i_gnt = 1'b0, m_d_gnt = 1'b0;

  // Sampled DUT outputs of the last cycle, for directed checks.
  logic              s_i_gnt, s_d_gnt, s_m_en, s_m_we, s_i_rvalid, s_d_rvalid;
  logic [3:0]        s_m_be;
  logic [ADDR_W-1:0] s_m_addr;
  logic [31:0]       s_m_wdata, s_i_rdata, s_d_rdata;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 32'd1));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] env_rd(input int w);
    return env_mem.exists(w) ? env_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    a = a | (($urandom & 32'hFFFF) << 16);
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance.
  task automatic run_cycle(input bit rst, input bit ireq, input logic [31:0] iaddr,
                           input bit dreq, input bit dwe, input logic [3:0] dbe,
                           input logic [31:0] daddr, input logic [31:0] dwdata);
    bit          e_i, e_d, e_iv, e_dv, e_en, e_we;
    logic [3:0]  e_be;
    int          e_addr;
    logic [31:0] e_wd;
    @(posedge CLK);
    #1;
    if (c_en && c_we) env_mem[c_addr] = merge(env_rd(c_addr), c_wdata, c_be);
    if (c_en && !c_we) M_RDATA = env_rd(c_addr);
    else M_RDATA = $urandom;
    RST = rst; I_REQ = ireq; I_ADDR = iaddr;
    D_REQ = dreq; D_WE = dwe; D_BE = dbe; D_ADDR = daddr; D_WDATA = dwdata;
    #4;
    // Fetch goes first only if data is idle or fetch already waited MAX_D grants.
    e_i  = !rst && ireq && (!dreq || run >= MAX_D);
    e_d  = !rst && dreq && !e_i;
    e_iv = !rst && pend_i;
    e_dv = !rst && pend_d;
    e_en = e_i || e_d;
    e_we = e_d && dwe;
    e_be = e_i ? 4'hF : (e_d ? dbe : 4'h0);
    e_addr = e_i ? word_of(iaddr) : (e_d ? word_of(daddr) : 0);
    e_wd = e_d ? dwdata : 32'h0;
    chk("i_gnt", I_GNT, e_i);
    chk("d_gnt", D_GNT, e_d);
    chk("m_en", M_EN, e_en);
    chk("m_we", M_WE, e_we);
    chk("m_be", M_BE, e_be);
    chk("m_addr", M_ADDR, e_addr);
    chk("m_wdata", M_WDATA, e_wd);
    chk("i_rvalid", I_RVALID, e_iv);
    chk("d_rvalid", D_RVALID, e_dv);
    chk("i_rdata_pass", I_RDATA, M_RDATA);
    chk("d_rdata_pass", D_RDATA, M_RDATA);
    if (e_iv) chk("i_rdata", I_RDATA, pend_data);
    if (e_dv) chk("d_rdata", D_RDATA, pend_data);
    s_i_gnt = I_GNT; s_d_gnt = D_GNT; s_m_en = M_EN; s_m_we = M_WE; s_m_be = M_BE;
    s_m_addr = M_ADDR; s_m_wdata = M_WDATA; s_i_rvalid = I_RVALID; s_d_rvalid = D_RVALID;
    s_i_rdata = I_RDATA; s_d_rdata = D_RDATA;
    c_en = M_EN; c_we = M_WE; c_be = M_BE; c_addr = int'(M_ADDR); c_wdata = M_WDATA;
    // Advance the model by one transaction.
    if (e_d && dwe) ref_mem[word_of(daddr)] = merge(ref_rd(word_of(daddr)), dwdata, dbe);
    pend_i = e_i;
    pend_d = e_d && !dwe;
    pend_data = e_i ? ref_rd(word_of(iaddr)) : ref_rd(word_of(daddr));
    if (rst || !ireq || e_i) run = 0;
    else if (e_d) run = run + 1;
    else run = run;
    m_i_gnt = e_i; m_d_gnt = e_d;
  endtask

  task automatic idle(input bit rst);
    run_cycle(rst, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [9:0]  ipat, dpat;
  logic [4:0]  ipat5;
  bit          h_i, h_d, h_we, rst_r;
  logic [31:0] h_ia, h_da, h_wd;
  logic [3:0]  h_be;

  // Main stimulus and checking sequence.
  initial begin
    RST = 1'b1; I_REQ = 1'b0; I_ADDR = 32'h0; D_REQ = 1'b0; D_WE = 1'b0;
    D_BE = 4'h0; D_ADDR = 32'h0; D_WDATA = 32'h0; M_RDATA = 32'h0;
    env_mem[4]  = 32'hDEAD_BEEF; ref_mem[4]  = 32'hDEAD_BEEF;
    env_mem[16] = 32'hCAFE_0016; ref_mem[16] = 32'hCAFE_0016;
    env_mem[17] = 32'h0BAD_0017; ref_mem[17] = 32'h0BAD_0017;

    // Reset holds grants low even with both ports requesting.
    run_cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    chk("rst_i_gnt", s_i_gnt, 1'b0);
    chk("rst_d_gnt", s_d_gnt, 1'b0);
    chk("rst_m_en", s_m_en, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("rst_i_rvalid", s_i_rvalid, 1'b0);
    chk("rst_d_rvalid", s_d_rvalid, 1'b0);

    // Fetch only.
    run_cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("f_i_gnt", s_i_gnt, 1'b1);
    chk("f_m_addr", s_m_addr, 14'd4);
    chk("f_m_be", s_m_be, 4'hF);
    idle(1'b0);
    chk("f_i_rvalid", s_i_rvalid, 1'b1);
    chk("f_i_rdata", s_i_rdata, 32'hDEAD_BEEF);
    chk("f_d_rvalid", s_d_rvalid, 1'b0);

    // Data write beats fetch.
    run_cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234);
    chk("w_d_gnt", s_d_gnt, 1'b1);
    chk("w_i_gnt", s_i_gnt, 1'b0);
    chk("w_m_we", s_m_we, 1'b1);
    chk("w_m_addr", s_m_addr, 14'd8);
    chk("w_m_wdata", s_m_wdata, 32'h1234);
    idle(1'b0);
    chk("w_no_irv", s_i_rvalid, 1'b0);
    chk("w_no_drv", s_d_rvalid, 1'b0);

    // Starvation guard with both ports held.
    idle(1'b0);
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
      ipat[k] = s_i_gnt;
      dpat[k] = s_d_gnt;
    end
    chk("streak_i_pat", ipat, 10'b10_0001_0000);
    chk("streak_d_pat", dpat, 10'b01_1110_1111);

    // Back-to-back reads: data at cycle 0, fetch at cycle 1.
    idle(1'b0);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    run_cycle(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("b2b_c1_drv", s_d_rvalid, 1'b1);
    chk("b2b_c1_drd", s_d_rdata, 32'hCAFE_0016);
    chk("b2b_c1_irv", s_i_rvalid, 1'b0);
    idle(1'b0);
    chk("b2b_c2_irv", s_i_rvalid, 1'b1);
    chk("b2b_c2_ird", s_i_rdata, 32'h0BAD_0017);
    chk("b2b_c2_drv", s_d_rvalid, 1'b0);
    idle(1'b0);
    chk("b2b_c3_irv", s_i_rvalid, 1'b0);

    // Reset right after a fetch grant kills its response.
    run_cycle(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("mr_i_gnt", s_i_gnt, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h48, 1'b1, 1'b0, 4'hF, 32'h4C, 32'h0);
    chk("mr_i_rvalid", s_i_rvalid, 1'b0);
    chk("mr_gnts", {s_i_gnt, s_d_gnt}, 2'b00);
    idle(1'b0);
    chk("mr_after_irv", s_i_rvalid, 1'b0);

    // Reset clears a partly built streak: full streak again afterwards.
    for (int k = 0; k < 3; k++)
      run_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
    run_cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
      ipat5[k] = s_i_gnt;
    end
    chk("rst_streak_pat", ipat5, 5'b10000);

    // Random traffic with held requests, withdrawals and occasional resets.
    h_i = 1'b0; h_d = 1'b0; h_we = 1'b0; h_ia = 32'h0; h_da = 32'h0;
    h_wd = 32'h0; h_be = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      if (h_i && !m_i_gnt) begin
        if ($urandom_range(0, 9) == 0) h_i = 1'b0;
      end else begin
        h_i  = ($urandom_range(0, 9) < 6);
        h_ia = rand_addr();
      end
      if (h_d && !m_d_gnt) begin
        if ($urandom_range(0, 9) == 0) h_d = 1'b0;
      end else begin
        h_d  = ($urandom_range(0, 9) < 6);
        h_we = $urandom_range(0, 1) == 1;
        h_be = 4'($urandom_range(0, 15));
        h_da = rand_addr();
        h_wd = $urandom;
      end
      rst_r = ($urandom_range(0, 49) == 0);
      run_cycle(rst_r, h_i, h_ia, h_d, h_we, h_be, h_da, h_wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
